// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types for the round-robin adder arbiter
package adder_arb_pkg;
    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/adder.sv
// adder: 32-bit combinational adder, carry-out dropped
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/adder_rr_arbiter_rr_grant.sv
// rr_grant: rotate-priority encoder, search starts at ptr and wraps at N-1 -> 0
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    int k;
    // Walk from farthest to nearest so the nearest requester is written last and wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            k = (int'(ptr) + j) % N;
            if (en && req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = IW'(k);
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: shares one adder among NUM_REQ requesters round-robin,
// registering each sum with its requester ID on a valid/ready response channel.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output data_t                     rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic [31:0]               op_count
);
    slot_state_t     r_state;
    data_t           r_sum;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_ptr;
    logic [31:0]     r_count;
    logic            w_slot_free;
    logic            w_accept;
    logic [ID_W-1:0] w_idx;
    data_t           w_sum;

    assign rsp_valid   = (r_state == SLOT_FULL);
    assign w_slot_free = !rsp_valid || rsp_ready;
    assign rsp_sum     = r_sum;
    assign rsp_id      = r_id;
    assign op_count    = r_count;

    // Gating with rst_n keeps req_ready low for the whole reset cycle
    rr_grant #(.N(NUM_REQ), .IW(ID_W)) u_grant (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (rst_n && w_slot_free),
        .gnt (req_ready),
        .idx (w_idx),
        .any (w_accept)
    );

    adder u_adder (
        .a   (req_a[DATA_W*w_idx +: DATA_W]),
        .b   (req_b[DATA_W*w_idx +: DATA_W]),
        .sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_state <= SLOT_FULL;
                r_sum   <= w_sum;
                r_id    <= w_idx;
                r_ptr   <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end else if (rsp_ready) begin
                r_state <= SLOT_EMPTY;
            end
            if (rsp_valid && rsp_ready)
                r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed plus randomized checks against a behavioural
// model of the arbiter (pointer, response slot, handshake counter).
module tb_adder_rr_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_sum;
    logic [1:0]      rsp_id;
    logic [31:0]     op_count;

    int checks = 0;
    int failures = 0;

    bit          m_valid = 0;
    logic [31:0] m_sum = 0;
    int          m_id = 0;
    int          m_ptr = 0;
    logic [31:0] m_count = 0;
    int          last_g = -1;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // One clock: check grant mid-cycle, advance the model across the edge, check outputs
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        logic [31:0] s;
        #3;
        g = -1;
        s = 0;
        if (rst_n && (!m_valid || rsp_ready))
            for (int j = 0; j < N; j++)
                if (g < 0 && req_valid[(m_ptr + j) % N]) g = (m_ptr + j) % N;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) s = req_a[32*g +: 32] + req_b[32*g +: 32];
        last_g = g;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_count = 0;
        end else begin
            if (m_valid && rsp_ready) m_count++;
            if (g >= 0) begin
                m_valid = 1; m_sum = s; m_id = g; m_ptr = (g + 1) % N;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("op_count", op_count, m_count);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;

        // single request
        req_valid = 4'b0001; set_op(0, 1, 2); rsp_ready = 1'b1;
        cycle();
        chk("single_gnt", 32'(last_g), 0);
        chk("single_sum", rsp_sum, 3);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_valid", 32'(rsp_valid), 1);
        req_valid = '0;
        cycle();
        chk("single_count", op_count, 1);

        // round-robin fairness from pointer 0
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, i, 10);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_gnt", 32'(last_g), k % N);
            chk("rr_sum", rsp_sum, 10 + k % N);
            chk("rr_id", 32'(rsp_id), k % N);
        end

        // backpressure
        req_valid = 4'b0001; set_op(0, 2, 3);
        cycle();
        chk("bp_pending", rsp_sum, 5);
        req_valid = 4'b0010; set_op(1, 7, 8); rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_nogrant", 32'(last_g), 32'hFFFF_FFFF);
            chk("bp_hold", rsp_sum, 5);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_release_gnt", 32'(last_g), 1);
        chk("bp_release_sum", rsp_sum, 15);

        // modulo-2^32 wrap
        req_valid = 4'b0100; set_op(2, 32'hFFFF_FFFF, 1);
        cycle();
        chk("wrap1", rsp_sum, 0);
        set_op(2, 32'h8000_0000, 32'h8000_0000);
        cycle();
        chk("wrap2", rsp_sum, 0);

        // pointer skip
        req_valid = 4'b0010; set_op(1, 4, 4);
        cycle();
        req_valid = 4'b0001; set_op(0, 9, 9);
        cycle();
        chk("skip_gnt0", 32'(last_g), 0);
        req_valid = 4'b0011;
        cycle();
        chk("skip_gnt1", 32'(last_g), 1);

        // reset mid-operation with a pending response
        req_valid = 4'b0100; set_op(2, 3, 4); rsp_ready = 1'b0;
        cycle();
        req_valid = 4'b1111; rst_n = 1'b0;
        cycle();
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_count", op_count, 0);
        rst_n = 1'b1; rsp_ready = 1'b1;
        cycle();
        chk("rst_first_gnt", 32'(last_g), 0);

        // randomized traffic honouring the hold-until-ready rule
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = $urandom_range(0, 1);
                    set_op(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                              ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
